// File: rtl/serializer_framed.sv
// rtl/serializer_framed.sv - FIFO-buffered framed one-wire serializer
module serializer_framed #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          data_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    state_t                w_next_state;
    logic [TW-1:0]         r_timer;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_fifo_nonempty;
    logic w_bit_end;
    logic w_last_data;
    logic w_last_stop;
    logic w_data_out;
    logic w_tx_done;

    assign w_in_ready      = (r_count != CW'(FIFO_DEPTH));
    assign w_push          = in_valid && w_in_ready;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_bit_end       = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_last_data     = (r_bit_cnt == BW'(DATA_WIDTH - 1));
    assign w_last_stop     = (r_bit_cnt == BW'(STOP_BITS - 1));

    assign in_ready   = w_in_ready;
    assign data_out   = w_data_out;
    assign tx_done    = w_tx_done;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || w_fifo_nonempty;

    // FIFO storage: written on every accepted push, never reset
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM next state, line value, pop request and end-of-frame pulse
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_done    = 1'b0;
        w_data_out   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_data_out = 1'b0;
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                w_data_out = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];
                if (w_bit_end && w_last_data) begin
                    w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_data_out = r_parity;
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                w_data_out = 1'b1;
                if (w_bit_end && w_last_stop) begin
                    w_tx_done = 1'b1;
                    // Only words already buffered before this edge chain directly
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state, bit timer, bit counter, shift register and parity capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_IDLE || w_bit_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            // The bit counter tracks data bits in DATA and stop bits in STOP
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                if (w_next_state != r_state) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end

            if (w_pop) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_parity <= (^r_mem[r_rd_ptr]) ^ (PARITY_ODD != 0);
            end else if (r_state == S_DATA && w_bit_end) begin
                if (MSB_FIRST != 0) begin
                    r_shift <= r_shift << 1;
                end else begin
                    r_shift <= r_shift >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serializer_framed.sv
// tb/tb_serializer_framed.sv - randomized self-checking bench for serializer_framed
module tb_serializer_framed;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] data_in;

    logic [2:0] w_data_out;
    logic [2:0] w_busy;
    logic [2:0] w_tx_done;
    logic [2:0] w_in_ready;
    logic [2:0] w_cnt0;
    logic [2:0] w_cnt1;
    logic [1:0] w_cnt2;

    int n_vec = 0;
    int n_err = 0;

    int cfg_cpb  [3];
    int cfg_msb  [3];
    int cfg_pen  [3];
    int cfg_podd [3];
    int cfg_stop [3];
    int cfg_dep  [3];

    // Reference state: buffered words and the remaining line bits of the current frame
    logic [7:0] m_q    [3][0:15];
    int         m_qn   [3];
    logic       m_fr   [3][0:63];
    int         m_flen [3];
    int         m_fpos [3];

    always #5 clock = ~clock;

    serializer_framed u0 (
        .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(w_in_ready[0]), .data_out(w_data_out[0]), .busy(w_busy[0]),
        .fifo_count(w_cnt0), .tx_done(w_tx_done[0])
    );

    serializer_framed #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(3), .MSB_FIRST(1),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) u1 (
        .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(w_in_ready[1]), .data_out(w_data_out[1]), .busy(w_busy[1]),
        .fifo_count(w_cnt1), .tx_done(w_tx_done[1])
    );

    serializer_framed #(
        .DATA_WIDTH(8), .FIFO_DEPTH(2), .CLKS_PER_BIT(2), .MSB_FIRST(0),
        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
    ) u2 (
        .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_ready(w_in_ready[2]), .data_out(w_data_out[2]), .busy(w_busy[2]),
        .fifo_count(w_cnt2), .tx_done(w_tx_done[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int n);
        case (n)
            0:       return {29'd0, w_cnt0};
            1:       return {29'd0, w_cnt1};
            default: return {30'd0, w_cnt2};
        endcase
    endfunction

    task automatic add_bit(input int n, input logic b);
        for (int c = 0; c < cfg_cpb[n]; c++) begin
            m_fr[n][m_flen[n]] = b;
            m_flen[n]++;
        end
    endtask

    // Whole-frame line waveform for one word: start, data, optional parity, stop
    task automatic build_frame(input int n, input logic [7:0] w);
        m_flen[n] = 0;
        m_fpos[n] = 0;
        add_bit(n, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add_bit(n, (cfg_msb[n] != 0) ? w[7 - i] : w[i]);
        end
        if (cfg_pen[n] != 0) begin
            add_bit(n, (^w) ^ (cfg_podd[n] != 0));
        end
        for (int s = 0; s < cfg_stop[n]; s++) begin
            add_bit(n, 1'b1);
        end
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge
    task automatic model_step();
        for (int n = 0; n < 3; n++) begin
            if (reset) begin
                m_qn[n]   = 0;
                m_flen[n] = 0;
                m_fpos[n] = 0;
            end else begin
                int         rem;
                logic       push;
                logic       pop;
                logic [7:0] w;
                rem  = m_flen[n] - m_fpos[n];
                push = in_valid && (m_qn[n] != cfg_dep[n]);
                pop  = (m_qn[n] > 0) && (rem <= 1);
                if (rem > 0) begin
                    m_fpos[n]++;
                end
                if (pop) begin
                    w = m_q[n][0];
                    for (int k = 1; k < m_qn[n]; k++) begin
                        m_q[n][k - 1] = m_q[n][k];
                    end
                    m_qn[n]--;
                    build_frame(n, w);
                end
                if (push) begin
                    m_q[n][m_qn[n]] = data_in;
                    m_qn[n]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int n = 0; n < 3; n++) begin
            int rem;
            rem = m_flen[n] - m_fpos[n];
            chk($sformatf("u%0d.data_out", n), {31'd0, w_data_out[n]},
                (rem > 0) ? {31'd0, m_fr[n][m_fpos[n]]} : 32'd1);
            chk($sformatf("u%0d.tx_done", n), {31'd0, w_tx_done[n]}, (rem == 1) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d.busy", n), {31'd0, w_busy[n]},
                ((rem > 0) || (m_qn[n] > 0)) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d.fifo_count", n), cnt_of(n), m_qn[n]);
            chk($sformatf("u%0d.in_ready", n), {31'd0, w_in_ready[n]},
                (m_qn[n] != cfg_dep[n]) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
        end
    endtask

    int   t1_exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic t1_got [10];
    int   prob;

    initial begin
        cfg_cpb  = '{1, 3, 2};
        cfg_msb  = '{0, 1, 0};
        cfg_pen  = '{0, 1, 1};
        cfg_podd = '{0, 0, 1};
        cfg_stop = '{1, 2, 1};
        cfg_dep  = '{4, 4, 2};
        for (int n = 0; n < 3; n++) begin
            m_qn[n]   = 0;
            m_flen[n] = 0;
            m_fpos[n] = 0;
        end

        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 8'h00;
        run(3);
        reset = 1'b0;
        run(2);

        // Single 0xA5 frame: exact line sequence on the default instance
        in_valid = 1'b1;
        data_in  = 8'hA5;
        tick();
        in_valid = 1'b0;
        data_in  = 8'h5A;
        tick();
        for (int i = 0; i < 10; i++) begin
            t1_got[i] = w_data_out[0];
            if (i == 9) begin
                chk("t1_tx_done_last", {31'd0, w_tx_done[0]}, 32'd1);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_bit%0d", i), {31'd0, t1_got[i]}, t1_exp[i]);
        end
        chk("t1_busy_after", {31'd0, w_busy[0]}, 32'd0);
        run(40);

        // Six words offered back to back while transmitting
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            data_in  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        run(250);

        // Push lands on the same edge as the end-of-frame pop with two words buffered
        in_valid = 1'b1;
        data_in  = 8'h11;
        tick();
        data_in  = 8'h22;
        tick();
        data_in  = 8'h33;
        tick();
        in_valid = 1'b0;
        run(8);
        chk("t4_tx_done", {31'd0, w_tx_done[0]}, 32'd1);
        chk("t4_cnt_before", {29'd0, w_cnt0}, 32'd2);
        in_valid = 1'b1;
        data_in  = 8'h44;
        tick();
        in_valid = 1'b0;
        chk("t4_cnt_after", {29'd0, w_cnt0}, 32'd2);
        chk("t4_start_bit", {31'd0, w_data_out[0]}, 32'd0);
        run(200);

        // 0xFF then 0x00 to expose the stop-bit gap between frames
        in_valid = 1'b1;
        data_in  = 8'hFF;
        tick();
        data_in  = 8'h00;
        tick();
        in_valid = 1'b0;
        run(90);

        // Reset during data bit 4 of 0x3C with two more words queued
        in_valid = 1'b1;
        data_in  = 8'h3C;
        tick();
        data_in  = 8'hC3;
        tick();
        data_in  = 8'h77;
        tick();
        in_valid = 1'b0;
        run(4);
        chk("t6_bit4", {31'd0, w_data_out[0]}, 32'd1);
        chk("t6_cnt_pre", {29'd0, w_cnt0}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_line", {31'd0, w_data_out[0]}, 32'd1);
        chk("t6_cnt", {29'd0, w_cnt0}, 32'd0);
        chk("t6_busy", {31'd0, w_busy[0]}, 32'd0);
        chk("t6_ready", {31'd0, w_in_ready[0]}, 32'd1);
        run(3);
        in_valid = 1'b1;
        data_in  = 8'h81;
        tick();
        in_valid = 1'b0;
        run(60);

        // Randomized traffic with varying load and occasional resets
        for (int blk = 0; blk < 10; blk++) begin
            prob = $urandom_range(5, 95);
            for (int i = 0; i < 200; i++) begin
                in_valid = ($urandom_range(0, 99) < prob);
                data_in  = 8'($urandom);
                reset    = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        run(250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
